// File: rtl/serial_pattern_det.sv
// ---------------------------------------------------------------------------
// serial_pattern_det
//   Serial bit-pattern detector with a runtime-loadable W-bit pattern and a
//   per-bit don't-care mask. Overlapping or non-overlapping detection is
//   selected per valid bit. Emits a registered one-cycle match pulse and,
//   optionally, a saturating match counter.
//
//   Optional feature macro: SERIAL_PATTERN_DET_CNT_EN
//     defined   -> match counter and clr_cnt logic are built
//     undefined -> match_cnt tied to 0, clr_cnt ignored
//
// Parameters:
//   W        pattern length in bits (2..32)
//   PATTERN  reset value of the pattern register (MSB = first bit received)
//   CNT_W    match counter width
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   x            serial data bit
//   x_valid      x is consumed on this edge when high
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   cfg_we       load cfg_pattern/cfg_mask and flush the detector
//   cfg_pattern  new pattern (MSB = first bit)
//   cfg_mask     1 = compare bit, 0 = don't care
//   clr_cnt      synchronous clear of match_cnt (wins over a same-edge hit)
//   z            registered match pulse
//   match_cnt    saturating match count
// ---------------------------------------------------------------------------
module serial_pattern_det #(
   parameter int unsigned    W       = 4,
   parameter logic [W-1:0]   PATTERN = W'(4'b0101),
   parameter int unsigned    CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             x_valid,
   input  logic             overlap,
   input  logic             cfg_we,
   input  logic [W-1:0]     cfg_pattern,
   input  logic [W-1:0]     cfg_mask,
   input  logic             clr_cnt,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int unsigned        FILL_W   = $clog2(W + 1);
   localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(W);

   logic [W-1:0]      shreg, shreg_n, shreg_sh;
   logic [W-1:0]      pat_q, pat_n;
   logic [W-1:0]      mask_q, mask_n;
   logic [FILL_W-1:0] fill, fill_n, fill_inc;
   logic              z_n;
   logic              hit;

   // Candidate window and saturating fill for the bit on this edge
   always_comb begin
      shreg_sh = {shreg[W-2:0], x};
      fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
      hit      = x_valid && !cfg_we && (fill_inc == FILL_MAX) &&
                 (((shreg_sh ^ pat_q) & mask_q) == '0);
   end

   // Next-state selection: config write flushes, valid bit shifts, idle holds
   always_comb begin
      shreg_n = shreg;
      fill_n  = fill;
      pat_n   = pat_q;
      mask_n  = mask_q;
      z_n     = 1'b0;
      if (cfg_we) begin
         pat_n   = cfg_pattern;
         mask_n  = cfg_mask;
         shreg_n = '0;
         fill_n  = '0;
      end else if (x_valid) begin
         z_n     = hit;
         shreg_n = shreg_sh;
         // Non-overlap: a match consumes the window, next one needs W fresh bits
         fill_n  = (hit && !overlap) ? '0 : fill_inc;
      end
   end

   // Detector state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg  <= '0;
         fill   <= '0;
         pat_q  <= PATTERN;
         mask_q <= '1;
         z      <= 1'b0;
      end else begin
         shreg  <= shreg_n;
         fill   <= fill_n;
         pat_q  <= pat_n;
         mask_q <= mask_n;
         z      <= z_n;
      end
   end

`ifdef SERIAL_PATTERN_DET_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_n;

   // Saturating match counter; clear beats a simultaneous hit
   always_comb begin
      cnt_n = cnt_q;
      if (clr_cnt)
         cnt_n = '0;
      else if (hit && (cnt_q != CNT_MAX))
         cnt_n = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_n;
   end

   assign match_cnt = cnt_q;
`else
   logic unused_clr_cnt;
   assign unused_clr_cnt = clr_cnt;
   assign match_cnt      = '0;
`endif

endmodule
